sum_accumulator: RTL and testbench
==================================

// Module: sum_accumulator
// PURPOSE
//   Downstream consumer of the Adder: takes a stream of Adder results (DATA_W+1 bits),
//   sums exactly NUM_TERMS of them into a wider register, then presents the total
//   on a valid/ready output port.
//   Forms the accumulate stage of the CA2 datapath: Adder -> sum_accumulator -> next stage.
// PARAMETERS
//   DATA_W     5  Adder operand width; sum_in is DATA_W+1 bits (Adder out incl. carry)
//   NUM_TERMS  4  Adder results summed per job (>=1)
//   ACC_W      8  accumulator/result width (>= DATA_W+1); total wraps modulo 2^ACC_W
// PORTS
//   clk        in   1          rising-edge clock
//   rst        in   1          synchronous reset, active-high
//   start      in   1          begin a new job (honoured in IDLE, or in DONE on result handoff)
//   sum_in     in   DATA_W+1   Adder result to accumulate
//   sum_valid  in   1          sum_in valid
//   sum_ready  out  1          block accepts sum_in this cycle
//   acc_out    out  ACC_W      accumulated total; meaningful only while acc_valid=1
//   acc_valid  out  1          result available
//   acc_ready  in   1          downstream takes the result
//   overflow   out  1          sticky: a carry left bit ACC_W-1 during the current job
//   busy       out  1          high in ACCUM and DONE
// BEHAVIOUR
//   - Control is fully synchronous on posedge clk. Every output is a register or decodes only state.
//   - FSM states: IDLE, ACCUM, DONE. Term counter cnt is $clog2(NUM_TERMS)+1 bits wide.
//   - rst=1 (priority over all inputs, any state, including mid-job):
//       state=IDLE, acc_out=0, cnt=0, overflow=0.
//       The outputs sum_ready, acc_valid and busy are all 0. Partial totals are discarded.
//   - IDLE: sum_ready=0, acc_valid=0, busy=0.
//       start=1 -> next cycle: state=ACCUM, acc_out=0, cnt=0, overflow=0.
//   - ACCUM: sum_ready=1, busy=1. start is ignored.
//       A transfer occurs when sum_valid&&sum_ready:
//         acc_out <= (acc_out + zero-extended sum_in) mod 2^ACC_W
//         overflow <= overflow | carry out of bit ACC_W-1
//         cnt <= cnt+1
//       A transfer with cnt==NUM_TERMS-1 -> state=DONE.
//       Cycles with sum_valid=0 change nothing.
//   - DONE: acc_valid=1, sum_ready=0, busy=1. acc_out and overflow are held stable.
//       acc_valid && acc_ready -> handoff:
//         with start=1 the same cycle -> ACCUM with acc_out, cnt and overflow cleared (back-to-back job)
//         otherwise -> IDLE
//       Without acc_ready the block stays in DONE indefinitely.
//   - Latency: acc_valid rises the cycle after the last term's transfer.
//       Minimum job length is NUM_TERMS+2 cycles: start, then NUM_TERMS transfers, then one cycle in DONE.
//   - acc_valid never asserts before NUM_TERMS terms are accepted.
//       sum_ready is never high outside ACCUM.
// TESTING
//   1. Basic job (defaults):
//        rst 2 cycles, start, then 4 x sum_in=61 with sum_valid=1 continuously
//        -> acc_valid=1 exactly 1 cycle after the 4th transfer, acc_out=244, overflow=0.
//   2. Wrap (ACC_W=7): same stimulus as test 1
//        -> acc_out=116 (244 mod 128), overflow=1. The next job starts with overflow=0.
//   3. Input gaps and back-pressure:
//        sum_valid pattern 1,0,0,1,1,0,1 with sums 1,2,3,4
//          -> acc_out=10.
//        Hold acc_ready=0 for 5 cycles in DONE
//          -> acc_out stays 10, sum_ready=0 throughout.
//        Then acc_ready=1 -> IDLE next cycle.
//   4. Reset mid-job: rst after 2 of 4 transfers
//        -> next cycle all outputs 0 and state IDLE.
//        A new start followed by 4 x 5 -> acc_out=20.
//   5. Back-to-back: in DONE, assert acc_ready=1 and start=1 in the same cycle
//        -> next cycle ACCUM, acc_out=0, sum_ready=1.
//        The second job with 4 x 1 -> acc_out=4.
//   6. start pulsed during ACCUM after the 1st transfer (sum=7)
//        -> ignored: cnt keeps counting, final result with 3 x 1 is acc_out=10.

Source files
------------

// File: rtl/sum_accumulator.sv
// Sums NUM_TERMS adder results into an ACC_W total; acc_valid rises the cycle after the last transfer.
// Input stalls on sum_valid=0; result holds in DONE until acc_ready, with sum_ready low throughout.
module sum_accumulator #(
   parameter int DATA_W    = 5,
   parameter int NUM_TERMS = 4,
   parameter int ACC_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W:0]   sum_in,
   input  logic              sum_valid,
   output logic              sum_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic              acc_valid,
   input  logic              acc_ready,
   output logic              overflow,
   output logic              busy
);

   localparam int CNT_W = $clog2(NUM_TERMS) + 1;

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic               sum_ready_q, sum_ready_d;
   logic               acc_valid_q, acc_valid_d;
   logic               busy_q, busy_d;
   logic [ACC_W:0]     acc_sum;

   // One extra bit catches the carry out of the top accumulator bit.
   assign acc_sum = {1'b0, acc_q} + (ACC_W+1)'(sum_in);

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ACCUM;
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         ACCUM: begin
            if (sum_valid && sum_ready_q) begin
               acc_d = acc_sum[ACC_W-1:0];
               ovf_d = ovf_q | acc_sum[ACC_W];
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(NUM_TERMS - 1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (acc_valid_q && acc_ready) begin
               if (start) begin
                  state_d = ACCUM;
                  acc_d   = '0;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Handshake outputs are registered copies of the next-state decode.
      sum_ready_d = (state_d == ACCUM);
      acc_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         sum_ready_q <= 1'b0;
         acc_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         sum_ready_q <= sum_ready_d;
         acc_valid_q <= acc_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign sum_ready = sum_ready_q;
   assign acc_out   = acc_q;
   assign acc_valid = acc_valid_q;
   assign overflow  = ovf_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Drives an 8-bit and a 7-bit accumulator with one directed stream; results checked by a scoreboard.
module tb_sum_accumulator;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [5:0] sum_in;
   logic       sum_valid;
   logic       acc_ready;

   logic       sum_ready8, acc_valid8, overflow8, busy8;
   logic [7:0] acc_out8;
   logic       sum_ready7, acc_valid7, overflow7, busy7;
   logic [6:0] acc_out7;

   typedef struct {
      logic [7:0] acc;
      logic       ovf;
   } exp_t;

   exp_t q8[$];
   exp_t q7[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   sum_accumulator #(.DATA_W(5), .NUM_TERMS(4), .ACC_W(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start), .sum_in(sum_in), .sum_valid(sum_valid),
      .sum_ready(sum_ready8), .acc_out(acc_out8), .acc_valid(acc_valid8),
      .acc_ready(acc_ready), .overflow(overflow8), .busy(busy8)
   );

   sum_accumulator #(.DATA_W(5), .NUM_TERMS(4), .ACC_W(7)) u_dut7 (
      .clk(clk), .rst(rst), .start(start), .sum_in(sum_in), .sum_valid(sum_valid),
      .sum_ready(sum_ready7), .acc_out(acc_out7), .acc_valid(acc_valid7),
      .acc_ready(acc_ready), .overflow(overflow7), .busy(busy7)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] e8, input logic o8, input logic [7:0] e7, input logic o7);
      exp_t e;
      e.acc = e8; e.ovf = o8; q8.push_back(e);
      e.acc = e7; e.ovf = o7; q7.push_back(e);
   endtask

   task automatic check_idle(input string tag);
      check({tag, " busy8"},      32'(busy8),      0);
      check({tag, " acc_valid8"}, 32'(acc_valid8), 0);
      check({tag, " sum_ready8"}, 32'(sum_ready8), 0);
      check({tag, " busy7"},      32'(busy7),      0);
   endtask

   // Monitor: results are consumed on handoff, compared against the scoreboard head.
   always @(negedge clk) begin
      if (acc_valid8 && acc_ready) begin
         if (q8.size() == 0) check("unexpected result w8", 32'(acc_out8), 32'hFFFF_FFFF);
         else begin
            exp_t e;
            e = q8.pop_front();
            check("result acc_out w8", 32'(acc_out8), 32'(e.acc));
            check("result overflow w8", 32'(overflow8), 32'(e.ovf));
         end
      end
      if (acc_valid7 && acc_ready) begin
         if (q7.size() == 0) check("unexpected result w7", 32'(acc_out7), 32'hFFFF_FFFF);
         else begin
            exp_t e;
            e = q7.pop_front();
            check("result acc_out w7", 32'(acc_out7), 32'(e.acc));
            check("result overflow w7", 32'(overflow7), 32'(e.ovf));
         end
      end
   end

   initial begin
      logic [6:0] vld_pat;
      logic [5:0] gap_sum;

      rst = 1'b1; start = 1'b0; sum_in = '0; sum_valid = 1'b0; acc_ready = 1'b0;
      tick(); tick();
      check_idle("reset");
      check("reset acc_out8",   32'(acc_out8),   0);
      check("reset overflow8",  32'(overflow8),  0);
      check("reset acc_out7",   32'(acc_out7),   0);
      rst = 1'b0;

      // Basic job and wrap: 4 x 61 = 244; mod 128 = 116 with overflow.
      start = 1'b1; tick(); start = 1'b0;
      check("t1 sum_ready after start", 32'(sum_ready8), 1);
      push(8'd244, 1'b0, 8'd116, 1'b1);
      sum_valid = 1'b1; sum_in = 6'd61;
      tick(); tick(); tick();
      check("t1 acc_valid before 4th", 32'(acc_valid8), 0);
      tick();
      sum_valid = 1'b0;
      check("t1 acc_valid after 4th", 32'(acc_valid8), 1);
      check("t1 sum_ready in done",   32'(sum_ready8), 0);
      check("t2 overflow7 in done",   32'(overflow7),  1);
      acc_ready = 1'b1; tick(); acc_ready = 1'b0;
      check_idle("t1 after handoff");

      // Next job clears the sticky overflow.
      start = 1'b1; tick(); start = 1'b0;
      check("t2 overflow7 cleared", 32'(overflow7), 0);
      check("t2 acc_out7 cleared",  32'(acc_out7),  0);

      // Gapped input 1,0,0,1,1,0,1 carrying 1,2,3,4 -> 10.
      push(8'd10, 1'b0, 8'd10, 1'b0);
      vld_pat = 7'b1011001;
      gap_sum = 6'd1;
      for (int i = 0; i < 7; i++) begin
         sum_valid = vld_pat[i];
         sum_in    = gap_sum;
         tick();
         if (vld_pat[i]) gap_sum = gap_sum + 6'd1;
      end
      sum_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("t3 held acc_out",   32'(acc_out8),   10);
         check("t3 held sum_ready", 32'(sum_ready8), 0);
         check("t3 held acc_valid", 32'(acc_valid8), 1);
         tick();
      end
      acc_ready = 1'b1; tick(); acc_ready = 1'b0;
      check_idle("t3 after handoff");

      // Reset after two of four transfers.
      start = 1'b1; tick(); start = 1'b0;
      sum_valid = 1'b1; sum_in = 6'd9;
      tick(); tick();
      sum_valid = 1'b0; rst = 1'b1;
      tick(); rst = 1'b0;
      check_idle("t4 mid-job reset");
      check("t4 acc_out8 reset",  32'(acc_out8),  0);
      check("t4 overflow8 reset", 32'(overflow8), 0);
      start = 1'b1; tick(); start = 1'b0;
      push(8'd20, 1'b0, 8'd20, 1'b0);
      sum_valid = 1'b1; sum_in = 6'd5;
      repeat (4) tick();
      sum_valid = 1'b0;
      check("t4 acc_valid", 32'(acc_valid8), 1);

      // Back-to-back: handoff and start in the same cycle.
      acc_ready = 1'b1; start = 1'b1; tick(); acc_ready = 1'b0; start = 1'b0;
      check("t5 sum_ready",  32'(sum_ready8), 1);
      check("t5 acc_out",    32'(acc_out8),   0);
      check("t5 acc_valid",  32'(acc_valid8), 0);
      check("t5 busy",       32'(busy8),      1);
      push(8'd4, 1'b0, 8'd4, 1'b0);
      sum_valid = 1'b1; sum_in = 6'd1;
      repeat (4) tick();
      sum_valid = 1'b0;
      acc_ready = 1'b1; tick(); acc_ready = 1'b0;
      check_idle("t5 after handoff");

      // start during ACCUM is ignored: 7 + 1 + 1 + 1 = 10.
      start = 1'b1; tick(); start = 1'b0;
      push(8'd10, 1'b0, 8'd10, 1'b0);
      sum_valid = 1'b1; sum_in = 6'd7;
      tick();
      start = 1'b1; sum_in = 6'd1;
      tick();
      start = 1'b0;
      tick();
      check("t6 acc_valid after 3rd", 32'(acc_valid8), 0);
      check("t6 partial acc_out",     32'(acc_out8),   9);
      tick();
      sum_valid = 1'b0;
      check("t6 acc_valid after 4th", 32'(acc_valid8), 1);
      acc_ready = 1'b1; tick(); acc_ready = 1'b0;
      check_idle("t6 after handoff");

      tick();
      check("scoreboard drained w8", 32'(q8.size()), 0);
      check("scoreboard drained w7", 32'(q7.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
